// File: rtl/plab4_net_router_domain_sched_if.sv
// Request/grant bundle between the per-domain input controllers, the output
// switch arbiters and the two-domain scheduler of one router input port.
interface plab4_net_router_domain_sched_if;
    logic [2:0] reqs_d1;
    logic [2:0] reqs_d2;
    logic [2:0] grants;
    logic [2:0] reqs;
    logic       domain;
    logic [2:0] grants_d1;
    logic [2:0] grants_d2;
    logic       prio;

    modport master (
        output reqs_d1, reqs_d2, grants,
        input  reqs, domain, grants_d1, grants_d2, prio
    );

    modport slave (
        input  reqs_d1, reqs_d2, grants,
        output reqs, domain, grants_d1, grants_d2, prio
    );
endinterface

// File: rtl/plab4_net_router_domain_sched.sv
// Two-domain scheduler: picks which domain's requests reach the switch, holds
// the pick until grant or withdrawal, and rotates priority after a burst.
module plab4_net_router_domain_sched #(
    parameter int unsigned p_burst_limit = 4
) (
    input logic                             clk,
    input logic                             reset,
    plab4_net_router_domain_sched_if.slave  port
);

    localparam int unsigned c_cnt_nbits = $clog2(p_burst_limit + 1);
    localparam logic [c_cnt_nbits:0] c_cnt_limit = (c_cnt_nbits + 1)'(p_burst_limit);
    localparam logic [c_cnt_nbits:0] c_cnt_one   = (c_cnt_nbits + 1)'(1);

    typedef enum logic [1:0] {StIdle, StHoldD1, StHoldD2} state_e;

    state_e                 state_q, state_d;
    logic                   prio_q, prio_d;
    logic [c_cnt_nbits-1:0] burst_cnt_q, burst_cnt_d;

    logic                   sel_dom;
    logic                   sel_valid;
    logic [2:0]             sel_reqs;
    logic                   xfer;
    logic [c_cnt_nbits:0]   cnt_inc;

    // In a HOLD state the domain stays selected even if its requests vanish,
    // so a withdrawal is seen as reqs == 000 rather than a change of domain.
    always_comb begin
        sel_dom   = 1'b0;
        sel_valid = 1'b0;
        unique case (state_q)
            StHoldD1: begin
                sel_dom   = 1'b0;
                sel_valid = 1'b1;
            end
            StHoldD2: begin
                sel_dom   = 1'b1;
                sel_valid = 1'b1;
            end
            default: begin
                if ((port.reqs_d1 != 3'b000) && (port.reqs_d2 != 3'b000)) begin
                    sel_dom   = prio_q;
                    sel_valid = 1'b1;
                end else if (port.reqs_d1 != 3'b000) begin
                    sel_dom   = 1'b0;
                    sel_valid = 1'b1;
                end else if (port.reqs_d2 != 3'b000) begin
                    sel_dom   = 1'b1;
                    sel_valid = 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        sel_reqs       = sel_dom ? port.reqs_d2 : port.reqs_d1;
        xfer           = !reset && sel_valid && ((sel_reqs & port.grants) != 3'b000);
        port.reqs      = reset ? 3'b000 : sel_reqs;
        port.domain    = !reset && sel_dom;
        port.grants_d1 = (!reset && sel_valid && !sel_dom) ? port.grants : 3'b000;
        port.grants_d2 = (!reset && sel_valid && sel_dom) ? port.grants : 3'b000;
        port.prio      = prio_q;
    end

    always_comb begin
        state_d     = state_q;
        prio_d      = prio_q;
        burst_cnt_d = burst_cnt_q;
        cnt_inc     = {1'b0, burst_cnt_q} + c_cnt_one;

        unique case (state_q)
            StHoldD1, StHoldD2: begin
                if (xfer || (sel_reqs == 3'b000)) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                if (sel_valid && !xfer) begin
                    state_d = sel_dom ? StHoldD2 : StHoldD1;
                end
            end
        endcase

        // Only the priority domain consumes its burst budget.
        if (xfer && (sel_dom == prio_q)) begin
            if (cnt_inc == c_cnt_limit) begin
                prio_d      = ~prio_q;
                burst_cnt_d = '0;
            end else begin
                burst_cnt_d = cnt_inc[c_cnt_nbits-1:0];
            end
        end

        if (reset) begin
            state_d     = StIdle;
            prio_d      = 1'b0;
            burst_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        state_q     <= state_d;
        prio_q      <= prio_d;
        burst_cnt_q <= burst_cnt_d;
    end

endmodule

// File: tb/tb_plab4_net_router_domain_sched.sv
// Self-checking bench: hand-derived vectors for a burst-limit-4 and a
// burst-limit-1 scheduler, compared through an expected-value queue.
module tb_plab4_net_router_domain_sched;

    logic clk;
    logic reset;

    plab4_net_router_domain_sched_if if_a ();
    plab4_net_router_domain_sched_if if_b ();

    plab4_net_router_domain_sched #(.p_burst_limit(4)) dut_a (
        .clk   (clk),
        .reset (reset),
        .port  (if_a)
    );

    plab4_net_router_domain_sched #(.p_burst_limit(1)) dut_b (
        .clk   (clk),
        .reset (reset),
        .port  (if_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       sel;   // 0: burst-limit-4 instance, 1: burst-limit-1 instance
        logic       rst;
        logic [2:0] r1;
        logic [2:0] r2;
        logic [2:0] g;
        logic [2:0] e_reqs;
        logic       e_dom;
        logic [2:0] e_g1;
        logic [2:0] e_g2;
        logic       e_prio;
        logic       chk_prio;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   n_checks;
    int   n_pass;
    int   n_vec;

    function automatic vec_t mk(input logic sel, input logic rst, input logic [2:0] r1,
                                input logic [2:0] r2, input logic [2:0] g,
                                input logic [2:0] e_reqs, input logic e_dom,
                                input logic [2:0] e_g1, input logic [2:0] e_g2,
                                input logic e_prio, input logic chk_prio);
        vec_t v;
        v.sel = sel; v.rst = rst; v.r1 = r1; v.r2 = r2; v.g = g;
        v.e_reqs = e_reqs; v.e_dom = e_dom; v.e_g1 = e_g1; v.e_g2 = e_g2;
        v.e_prio = e_prio; v.chk_prio = chk_prio;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [2:0] act,
                         input logic [2:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s vec %0d: got %b expected %b", name, idx, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        vec_t e;
        @(negedge clk);
        reset = v.rst;
        if (v.sel == 1'b0) begin
            if_a.reqs_d1 = v.r1; if_a.reqs_d2 = v.r2; if_a.grants = v.g;
            if_b.reqs_d1 = 3'b000; if_b.reqs_d2 = 3'b000; if_b.grants = 3'b000;
        end else begin
            if_b.reqs_d1 = v.r1; if_b.reqs_d2 = v.r2; if_b.grants = v.g;
            if_a.reqs_d1 = 3'b000; if_a.reqs_d2 = 3'b000; if_a.grants = 3'b000;
        end
        exp_q.push_back(v);
        #2;
        e = exp_q.pop_front();
        if (e.sel == 1'b0) begin
            check("a.reqs", n_vec, if_a.reqs, e.e_reqs);
            check("a.domain", n_vec, {2'b00, if_a.domain}, {2'b00, e.e_dom});
            check("a.grants_d1", n_vec, if_a.grants_d1, e.e_g1);
            check("a.grants_d2", n_vec, if_a.grants_d2, e.e_g2);
            if (e.chk_prio) check("a.prio", n_vec, {2'b00, if_a.prio}, {2'b00, e.e_prio});
        end else begin
            check("b.reqs", n_vec, if_b.reqs, e.e_reqs);
            check("b.domain", n_vec, {2'b00, if_b.domain}, {2'b00, e.e_dom});
            check("b.grants_d1", n_vec, if_b.grants_d1, e.e_g1);
            check("b.grants_d2", n_vec, if_b.grants_d2, e.e_g2);
            if (e.chk_prio) check("b.prio", n_vec, {2'b00, if_b.prio}, {2'b00, e.e_prio});
        end
        n_vec++;
    endtask

    initial begin
        clk = 1'b0;
        reset = 1'b1;
        n_checks = 0;
        n_pass = 0;
        n_vec = 0;
        if_a.reqs_d1 = 3'b000; if_a.reqs_d2 = 3'b000; if_a.grants = 3'b000;
        if_b.reqs_d1 = 3'b000; if_b.reqs_d2 = 3'b000; if_b.grants = 3'b000;

        // Reset with live inputs: outputs forced to zero.
        repeat (2) vecs.push_back(mk(0, 1, 3'b001, 3'b010, 3'b001, 3'b000, 0, 3'b000, 3'b000, 0, 1));
        // Lone d1 granted every cycle: prio flips after the 4th transfer.
        for (int i = 0; i < 6; i++)
            vecs.push_back(mk(0, 0, 3'b100, 3'b000, 3'b100, 3'b100, 0, 3'b100, 3'b000,
                              (i >= 4) ? 1'b1 : 1'b0, 1));
        // Re-reset to restart from prio 0 (also resets the limit-1 instance).
        vecs.push_back(mk(0, 1, 3'b000, 3'b000, 3'b000, 3'b000, 0, 3'b000, 3'b000, 0, 0));
        // Both requesting, granted every cycle: 0,0,0,0,1,1,1,1,0.
        for (int i = 0; i < 9; i++) begin
            if (i >= 4 && i < 8)
                vecs.push_back(mk(0, 0, 3'b001, 3'b010, 3'b010, 3'b010, 1, 3'b000, 3'b010, 1, 1));
            else
                vecs.push_back(mk(0, 0, 3'b001, 3'b010, 3'b001, 3'b001, 0, 3'b001, 3'b000, 0, 1));
        end
        // HOLD_D1 for 3 ungranted cycles, granted on the 4th.
        repeat (3) vecs.push_back(mk(0, 0, 3'b001, 3'b010, 3'b000, 3'b001, 0, 3'b000, 3'b000, 0, 1));
        vecs.push_back(mk(0, 0, 3'b001, 3'b010, 3'b001, 3'b001, 0, 3'b001, 3'b000, 0, 1));
        // HOLD_D2 then withdrawal; stray grant is steered but not a transfer.
        vecs.push_back(mk(0, 0, 3'b000, 3'b010, 3'b000, 3'b010, 1, 3'b000, 3'b000, 0, 1));
        vecs.push_back(mk(0, 0, 3'b001, 3'b000, 3'b001, 3'b000, 1, 3'b000, 3'b001, 0, 1));
        // Burst count was untouched by the withdrawal: flip on the 2nd transfer here.
        repeat (2) vecs.push_back(mk(0, 0, 3'b001, 3'b000, 3'b001, 3'b001, 0, 3'b001, 3'b000, 0, 1));
        vecs.push_back(mk(0, 0, 3'b000, 3'b000, 3'b000, 3'b000, 0, 3'b000, 3'b000, 1, 1));
        // Non-overlapping grant locks HOLD_D1; d2 with priority cannot break it.
        vecs.push_back(mk(0, 0, 3'b100, 3'b000, 3'b001, 3'b100, 0, 3'b001, 3'b000, 1, 1));
        vecs.push_back(mk(0, 0, 3'b100, 3'b010, 3'b010, 3'b100, 0, 3'b010, 3'b000, 1, 1));
        vecs.push_back(mk(0, 0, 3'b100, 3'b010, 3'b100, 3'b100, 0, 3'b100, 3'b000, 1, 1));
        vecs.push_back(mk(0, 0, 3'b100, 3'b010, 3'b010, 3'b010, 1, 3'b000, 3'b010, 1, 1));

        foreach (vecs[i]) apply(vecs[i]);

        // Burst limit 1: strict alternation, then reset in the middle of HOLD_D2.
        for (int i = 0; i < 5; i++) begin
            if (i % 2 == 1)
                apply(mk(1, 0, 3'b001, 3'b010, 3'b010, 3'b010, 1, 3'b000, 3'b010, 1, 1));
            else
                apply(mk(1, 0, 3'b001, 3'b010, 3'b001, 3'b001, 0, 3'b001, 3'b000, 0, 1));
        end
        repeat (2) apply(mk(1, 0, 3'b001, 3'b010, 3'b000, 3'b010, 1, 3'b000, 3'b000, 1, 1));
        apply(mk(1, 1, 3'b001, 3'b010, 3'b010, 3'b000, 0, 3'b000, 3'b000, 0, 0));
        apply(mk(1, 0, 3'b001, 3'b010, 3'b000, 3'b001, 0, 3'b000, 3'b000, 0, 1));
        apply(mk(1, 0, 3'b001, 3'b010, 3'b001, 3'b001, 0, 3'b001, 3'b000, 0, 1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/plab4_net_router_domain_sched.md
Name: plab4_net_router_domain_sched

Overview:
- Sequential two-domain scheduler for one router input port.
- Sits between the per-domain input controllers (domain1 and domain2 buffers) and the router's output switch arbiters.
- Selects which domain's 3-bit request vector reaches the switch. It holds that choice until the request is granted or withdrawn, and applies a burst-limited fairness policy.
- Steers the returned grants back to the selected domain only.

Parameters:
- p_burst_limit, 4: maximum consecutive transfers by the priority domain before priority flips to the other domain. Legal range is 1..15; 1 gives strict alternation.
- c_cnt_nbits, $clog2(p_burst_limit+1): burst counter width. Derived; not set from outside.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- reqs_d1  input  3  request vector from the domain1 input controller; 000 means no request.
- reqs_d2  input  3  request vector from the domain2 input controller.
- grants  input  3  one-hot or zero grant vector returned by the output switch arbiters.
- reqs  output  3  request vector of the selected domain, presented to the switch.
- domain  output  1  selected domain (0 = d1, 1 = d2); drives the datapath mux.
- grants_d1  output  3  grants steered to domain1; 000 when domain1 is not selected.
- grants_d2  output  3  grants steered to domain2; 000 when domain2 is not selected.
- prio  output  1  current priority domain (for debug and verification).

Behaviour:
- State: fsm (IDLE, HOLD_D1, HOLD_D2), prio (1 bit), burst_cnt (c_cnt_nbits bits).
- Reset: fsm=IDLE, prio=0, burst_cnt=0.
- While reset is high, outputs are forced to reqs=000, domain=0, grants_d1=000, grants_d2=000. The prio output equals 0 from the first cycle after reset is sampled.
- Candidate selection in IDLE (combinational):
  - only reqs_d1 nonzero -> d1;
  - only reqs_d2 nonzero -> d2;
  - both nonzero -> the prio domain;
  - neither -> reqs=000, domain=0.
- In HOLD_Dx the selection is domain x, regardless of the other domain or prio.
- Outputs:
  - reqs = reqs_dx of the selected domain; domain = x.
  - grants_dx = grants for the selected domain; the other domain's grants = 000.
  - There is no decision latency: reqs and grants appear in the same cycle (zero-cycle combinational path).
- Transfer: xfer = |(reqs & grants), evaluated in the cycle it occurs.
- Transitions:
  - IDLE, candidate exists, xfer=1 -> stay IDLE.
  - IDLE, candidate exists, xfer=0 -> HOLD_D(candidate). This locks the selection so the switch never sees reqs change mid-arbitration.
  - HOLD_Dx, xfer=1 -> IDLE.
  - HOLD_Dx, reqs_dx becomes 000 (withdrawn) -> IDLE, with no transfer and no counter update.
  - HOLD_Dx otherwise -> stay.
- Fairness update, on xfer by the selected domain s:
  - if s == prio: when burst_cnt+1 == p_burst_limit, prio <= ~prio and burst_cnt <= 0; otherwise burst_cnt <= burst_cnt+1.
  - if s != prio: prio and burst_cnt are unchanged.
  - Priority flips even if the other domain is idle. This is harmless because a lone requester always wins.
- Grants arriving with no overlap with reqs (grants & reqs == 0) are not a transfer: no state change.
- A HOLD state is never exited because the other domain requests; only a grant or a withdrawal exits it.
- Reset mid-HOLD: returns to IDLE next cycle; any pending selection is discarded.
- burst_cnt never exceeds p_burst_limit-1.

Test Plan:
- Reset held 2 cycles with reqs_d1=001, reqs_d2=010, grants=001 -> reqs=000, grants_d1=000, grants_d2=000, domain=0. After release: fsm=IDLE, prio=0, burst_cnt=0.
- Only reqs_d1=100 with grants=100 every cycle for 6 cycles -> reqs=100, domain=0, grants_d1=100, grants_d2=000, 6 transfers. With p_burst_limit=4, prio flips to 1 after the 4th transfer while d1 keeps winning.
- Both domains request continuously (reqs_d1=001, reqs_d2=010), switch grants every cycle, p_burst_limit=4 -> domain sequence 0,0,0,0,1,1,1,1,0,... and prio toggles every 4 transfers.
- Both request, grants=000 for 3 cycles, then grants=001 -> domain stays 0 and reqs stays 001 throughout HOLD_D1 while reqs_d2=010 stays asserted. Transfer occurs on cycle 4 and fsm returns to IDLE.
- HOLD_D2 with reqs_d2 dropping to 000 before any grant -> fsm returns to IDLE next cycle; prio and burst_cnt unchanged; a pending reqs_d1=001 is selected next cycle.
- p_burst_limit=1, both requesting, grants every cycle -> strict alternation 0,1,0,1. Then assert reset during HOLD_D2 -> IDLE and prio=0 after one cycle.
